// File: rtl/gamepad_pkg.sv
// Shared types and constants for the serial gamepad receiver.
package gamepad_pkg;

  typedef enum logic [1:0] {GP_IDLE, GP_SHIFT, GP_BAD} gp_state_t;

  localparam int ERR_W = 8;

endpackage

// File: rtl/gp_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin plus rising-edge detect on the synchronised level.
module gp_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic lvl_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_dly_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= '0;
      lvl_dly_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pin_i};
      lvl_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign lvl_o  = sync_q[SYNC_STAGES-1];
  assign rise_o = lvl_o & ~lvl_dly_q;

endmodule

// File: rtl/gamepad_rx_multi.sv
// Latch/clock/data gamepad receiver: frame timing validation, N-frame agreement before commit,
// press/release pulses, error counting and presence timeout.
module gamepad_rx_multi
  import gamepad_pkg::*;
#(
  parameter int NCH         = 1,
  parameter int NBITS       = 24,
  parameter int CW          = 12,
  parameter int SYNC_STAGES = 2,
  parameter int MATCH       = 2,
  parameter int TOW         = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 gp_latch,
  input  logic                 gp_clk,
  input  logic [NCH-1:0]       gp_data,
  output logic [NCH*NBITS-1:0] buttons,
  output logic [NCH*NBITS-1:0] pressed,
  output logic [NCH*NBITS-1:0] released,
  output logic                 frame_ok,
  output logic                 frame_err,
  output logic [ERR_W-1:0]     err_count,
  output logic                 present
);

  localparam int NB = NCH * NBITS;
  localparam int TW = $clog2(NBITS + 1);
  localparam logic [CW-1:0]  CNT_MAX = '1;
  localparam logic [TOW-1:0] TO_MAX  = '1;
  localparam logic [TOW-1:0] TO_LAST = TO_MAX - 1'b1;

  logic           latch_lvl, latch_rise, clk_lvl, clk_rise;
  logic [NCH-1:0] data_lvl, data_rise;
  logic           unused_edges;

  gp_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
    .clk(clk), .rst_n(rst_n), .pin_i(gp_latch), .lvl_o(latch_lvl), .rise_o(latch_rise)
  );

  gp_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst_n(rst_n), .pin_i(gp_clk), .lvl_o(clk_lvl), .rise_o(clk_rise)
  );

  assign unused_edges = ^{clk_lvl, data_rise};

  gp_state_t      state_q;
  logic [TW-1:0]  ticks_q;
  logic [CW-1:0]  cnt_q, last_q;
  logic [NB-1:0]  frame_d, frame_q, cand_q;
  logic           cand_vld_q, commit_q;
  logic [NB-1:0]  buttons_q, pressed_q, released_q;
  logic           frame_ok_q, frame_err_q, present_q;
  logic [ERR_W-1:0] err_q;
  logic [TOW-1:0] to_q;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_line
    logic [NBITS-1:0] sh_q;

    gp_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
      .clk(clk), .rst_n(rst_n), .pin_i(gp_data[ch]), .lvl_o(data_lvl[ch]), .rise_o(data_rise[ch])
    );

    always_ff @(posedge clk) begin
      if (latch_rise)
        sh_q <= '0;
      else if (state_q == GP_SHIFT && clk_rise)
        sh_q <= {sh_q[NBITS-2:0], data_lvl[ch]};
    end

    assign frame_d[ch*NBITS +: NBITS] = sh_q;
  end

  // Interval checks widened by one bit so doubling never wraps.
  logic [CW:0] cnt_x, last_x, cnt2_x, last2_x;
  logic        close_good, interval_bad, cand_match;

  assign cnt_x        = {1'b0, cnt_q};
  assign last_x       = {1'b0, last_q};
  assign cnt2_x       = {cnt_q, 1'b0};
  assign last2_x      = {last_q, 1'b0};
  assign close_good   = (state_q == GP_SHIFT) && (ticks_q == TW'(NBITS)) && (cnt_x <= last2_x);
  assign interval_bad = (ticks_q > TW'(1)) && ((cnt_x > last2_x) || (cnt2_x < last_x));
  assign cand_match   = cand_vld_q && (frame_d == cand_q);

  always_ff @(posedge clk) begin
    if (latch_rise) begin
      frame_q <= frame_d;
      if (close_good)
        cand_q <= frame_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= GP_IDLE;
      ticks_q     <= '0;
      cnt_q       <= '0;
      last_q      <= '0;
      cand_vld_q  <= 1'b0;
      commit_q    <= 1'b0;
      buttons_q   <= '0;
      pressed_q   <= '0;
      released_q  <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_q       <= '0;
      present_q   <= 1'b0;
      to_q        <= '0;
    end else begin
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      commit_q    <= 1'b0;
      pressed_q   <= '0;
      released_q  <= '0;

      // A latch edge closes the open frame and always reopens a fresh one; a
      // coincident shift-clock edge is deliberately dropped.
      if (latch_rise) begin
        state_q <= GP_SHIFT;
        ticks_q <= '0;
        cnt_q   <= '0;
        last_q  <= '0;
        if (close_good) begin
          frame_ok_q <= 1'b1;
          commit_q   <= (MATCH == 1) || cand_match;
          cand_vld_q <= 1'b1;
        end else begin
          cand_vld_q <= 1'b0;
          if (state_q != GP_IDLE) begin
            frame_err_q <= 1'b1;
            if (err_q != '1)
              err_q <= err_q + 1'b1;
          end
        end
      end else if (state_q == GP_SHIFT) begin
        if (clk_rise) begin
          ticks_q <= ticks_q + 1'b1;
          last_q  <= cnt_q;
          cnt_q   <= '0;
          if (latch_lvl || (ticks_q == TW'(NBITS)) || interval_bad)
            state_q <= GP_BAD;
        end else if (ticks_q != '0) begin
          if (cnt_q == CNT_MAX)
            state_q <= GP_BAD;
          else
            cnt_q <= cnt_q + 1'b1;
        end
      end

      if (commit_q) begin
        buttons_q  <= frame_q;
        pressed_q  <= frame_q & ~buttons_q;
        released_q <= buttons_q & ~frame_q;
      end

      if (latch_rise && close_good) begin
        to_q      <= '0;
        present_q <= 1'b1;
      end else if (to_q != TO_MAX) begin
        to_q <= to_q + 1'b1;
        if (to_q == TO_LAST) begin
          present_q  <= 1'b0;
          buttons_q  <= '0;
          released_q <= buttons_q;
          cand_vld_q <= 1'b0;
        end
      end
    end
  end

  assign buttons   = buttons_q;
  assign pressed   = pressed_q;
  assign released  = released_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_count = err_q;
  assign present   = present_q;

endmodule

// File: tb/tb_gamepad_rx_multi.sv
// Directed bench for gamepad_rx_multi: two lines of 12 bits, two-frame agreement, short timeout.
module tb_gamepad_rx_multi;

  localparam int NCH   = 2;
  localparam int NBITS = 12;
  localparam int NB    = NCH * NBITS;
  localparam int TOW   = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          gp_latch = 1'b0;
  logic          gp_clk = 1'b0;
  logic [1:0]    gp_data = '0;
  logic [NB-1:0] buttons, pressed, released;
  logic          frame_ok, frame_err, present;
  logic [7:0]    err_count;

  gamepad_rx_multi #(
    .NCH(NCH), .NBITS(NBITS), .CW(12), .SYNC_STAGES(2), .MATCH(2), .TOW(TOW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .gp_latch(gp_latch), .gp_clk(gp_clk), .gp_data(gp_data),
    .buttons(buttons), .pressed(pressed), .released(released),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_count(err_count), .present(present)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0, n_ok = 0, n_err = 0, ok_cyc = 0, drop_cyc = 0, prs_cnt = 0, rel_cnt = 0;
  logic [NB-1:0] prs_last = '0, rel_last = '0;
  logic present_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (frame_ok) begin n_ok++; ok_cyc = cyc; end
    if (frame_err) n_err++;
    if (pressed != '0) begin prs_cnt++; prs_last = pressed; end
    if (released != '0) begin rel_cnt++; rel_last = released; end
    if (present_prev && !present) drop_cyc = cyc;
    present_prev = present;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [11:0] l0, input logic [11:0] l1,
                            input int npulse, input int gap_at);
    for (int i = 0; i < npulse; i++) begin
      gp_clk = 1'b0;
      gp_data = (i < NBITS) ? {l1[NBITS-1-i], l0[NBITS-1-i]} : 2'b00;
      wait_n(8);
      gp_clk = 1'b1;
      wait_n((i == gap_at) ? 32 : 8);
    end
  endtask

  task automatic latch_pulse();
    gp_latch = 1'b1;
    wait_n(8);
    gp_latch = 1'b0;
    wait_n(8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_n(4);
    check_vec("rst_buttons", buttons, 0);
    check_vec("rst_pressed", pressed, 0);
    check_vec("rst_released", released, 0);
    check_vec("rst_frame_ok", frame_ok, 0);
    check_vec("rst_frame_err", frame_err, 0);
    check_vec("rst_err_count", err_count, 0);
    check_vec("rst_present", present, 0);
    rst_n = 1'b1;
    wait_n(2);

    latch_pulse();
    check_vec("first_latch_no_err", n_err, 0);
    check_vec("first_latch_no_ok", n_ok, 0);

    send_frame(12'hA05, 12'h3C0, 12, -1); latch_pulse();
    check_vec("f1_ok", n_ok, 1);
    check_vec("f1_no_commit", buttons, 0);
    send_frame(12'hA05, 12'h3C0, 12, -1); latch_pulse();
    check_vec("f2_ok", n_ok, 2);
    check_vec("f2_buttons", buttons, 24'h3C0A05);
    check_vec("f2_pressed", prs_last, 24'h3C0A05);
    check_vec("f2_pressed_once", prs_cnt, 1);
    check_vec("f2_present", present, 1);

    send_frame(12'hA04, 12'h3C0, 12, -1); latch_pulse();
    check_vec("f3_ok", n_ok, 3);
    check_vec("f3_hold", buttons, 24'h3C0A05);
    send_frame(12'hA04, 12'h3C0, 12, -1); latch_pulse();
    check_vec("f4_buttons", buttons, 24'h3C0A04);
    check_vec("f4_released", rel_last, 24'h000001);
    check_vec("f4_released_once", rel_cnt, 1);
    check_vec("f4_no_press", prs_cnt, 1);

    send_frame(12'hA05, 12'h3C0, 12, -1); latch_pulse();
    check_vec("f5_ok", n_ok, 5);
    send_frame(12'hA05, 12'h3C0, 12, 5); latch_pulse();
    check_vec("gap_err", n_err, 1);
    check_vec("gap_err_count", err_count, 1);
    check_vec("gap_buttons", buttons, 24'h3C0A04);
    send_frame(12'hA05, 12'h3C0, 12, -1); latch_pulse();
    check_vec("cand_cleared", buttons, 24'h3C0A04);
    send_frame(12'hA05, 12'h3C0, 12, -1); latch_pulse();
    check_vec("recommit_buttons", buttons, 24'h3C0A05);
    check_vec("recommit_pressed", prs_last, 24'h000001);
    check_vec("recommit_pressed_once", prs_cnt, 2);

    send_frame(12'hA05, 12'h3C0, 13, -1); latch_pulse();
    check_vec("p13_err", n_err, 2);
    check_vec("p13_err_count", err_count, 2);
    send_frame(12'hA05, 12'h3C0, 11, -1); latch_pulse();
    check_vec("p11_err", n_err, 3);
    check_vec("p11_err_count", err_count, 3);
    check_vec("err_buttons", buttons, 24'h3C0A05);

    send_frame(12'hA04, 12'h3C0, 12, -1);
    gp_clk = 1'b0;
    wait_n(8);
    gp_latch = 1'b1;
    gp_clk = 1'b1;
    wait_n(8);
    gp_latch = 1'b0;
    wait_n(8);
    send_frame(12'hA04, 12'h3C0, 12, -1); latch_pulse();
    check_vec("coinc_ok", n_ok, 9);
    check_vec("coinc_no_err", n_err, 3);
    check_vec("coinc_buttons", buttons, 24'h3C0A04);
    check_vec("coinc_released", rel_last, 24'h000001);
    check_vec("coinc_released_cnt", rel_cnt, 2);

    for (int i = 0; i < 3000 && present; i++) wait_n(1);
    wait_n(2);
    check_vec("to_present", present, 0);
    check_vec("to_delay", drop_cyc - ok_cyc, (1 << TOW) - 1);
    check_vec("to_buttons", buttons, 0);
    check_vec("to_released", rel_last, 24'h3C0A04);
    check_vec("to_released_cnt", rel_cnt, 3);

    send_frame(12'hA05, 12'h3C0, 3, -1);
    wait_n(4200);
    latch_pulse();
    check_vec("sat_err", n_err, 4);
    check_vec("sat_err_count", err_count, 4);

    send_frame(12'hA05, 12'h3C0, 12, -1); latch_pulse();
    send_frame(12'hA05, 12'h3C0, 12, -1); latch_pulse();
    check_vec("pre_rst_buttons", buttons, 24'h3C0A05);
    check_vec("pre_rst_present", present, 1);
    send_frame(12'hA05, 12'h3C0, 5, -1);
    rst_n = 1'b0;
    wait_n(3);
    rst_n = 1'b1;
    wait_n(4);
    check_vec("mid_rst_buttons", buttons, 0);
    check_vec("mid_rst_present", present, 0);
    check_vec("mid_rst_err_count", err_count, 0);
    send_frame(12'hA05, 12'h3C0, 7, -1); latch_pulse();
    check_vec("post_rst_no_err", n_err, 4);
    check_vec("post_rst_no_ok", n_ok, 11);
    check_vec("post_rst_err_count", err_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
